// File: rtl/combo_lock_ctrl_pkg.sv
// Shared types and display codes for the combination lock controller.
package combo_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } lockState_t;

    localparam logic [3:0] DISP_LOCKED   = 4'h0;
    localparam logic [3:0] DISP_UNLOCKED = 4'h1;
    localparam logic [3:0] DISP_HOLD     = 4'h2;

    // Status code shown for a given controller state.
    function automatic logic [3:0] dispCode(input lockState_t s);
        case (s)
            UNLOCKED: return DISP_UNLOCKED;
            LOCKOUT:  return DISP_HOLD;
            default:  return DISP_LOCKED;
        endcase
    endfunction

endpackage

// File: rtl/combo_lock_ctrl_btn_edge_sync.sv
// Two-flop synchronizer and rising-edge detector producing a one-cycle Pulse per press.
module btn_edge_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn,
    output logic Pulse
);

    logic [1:0] syncQ;
    logic       prevQ;
    logic [1:0] fillQ;
    logic       armedQ;

    // Arm only after the synchronized button has been seen low, so a button
    // held through reset release cannot produce a press.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            syncQ  <= '0;
            prevQ  <= 1'b0;
            fillQ  <= '0;
            armedQ <= 1'b0;
            Pulse  <= 1'b0;
        end else begin
            syncQ  <= {syncQ[0], Btn};
            prevQ  <= syncQ[1];
            fillQ  <= {fillQ[0], 1'b1};
            armedQ <= armedQ | (fillQ[1] & ~syncQ[1]);
            Pulse  <= armedQ & syncQ[1] & ~prevQ;
        end
    end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Four-digit combination lock: digit capture, code check, fail counting and timed lockout.
module combo_lock_ctrl
    import combo_lock_ctrl_pkg::*;
#(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] DigitIn,
    input  logic       BtnEnter,
    input  logic       BtnClear,
    output logic [3:0] DispVal,
    output logic       Unlocked,
    output logic [1:0] DigitCnt,
    output logic [2:0] FailCnt
);

    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] FAIL_MAX = 3'(MAX_FAILS);

    logic enterPulse;
    logic clearPulse;

    btn_edge_sync uEnterSync (.Clk(Clk), .Rst(Rst), .Btn(BtnEnter), .Pulse(enterPulse));
    btn_edge_sync uClearSync (.Clk(Clk), .Rst(Rst), .Btn(BtnClear), .Pulse(clearPulse));

    lockState_t        state, stateNext;
    logic [3:0][3:0]   slots, slotsNext;
    logic [LOCK_W-1:0] lockCnt, lockCntNext;
    logic [1:0]        digitCntNext;
    logic [2:0]        failCntNext;
    logic [2:0]        failInc;
    logic [3:0]        dispNext;
    logic              unlockedNext;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= LOCKED;
            slots    <= '0;
            lockCnt  <= '0;
            DigitCnt <= '0;
            FailCnt  <= '0;
            DispVal  <= DISP_LOCKED;
            Unlocked <= 1'b0;
        end else begin
            state    <= stateNext;
            slots    <= slotsNext;
            lockCnt  <= lockCntNext;
            DigitCnt <= digitCntNext;
            FailCnt  <= failCntNext;
            DispVal  <= dispNext;
            Unlocked <= unlockedNext;
        end
    end

    always_comb begin
        stateNext    = state;
        slotsNext    = slots;
        lockCntNext  = lockCnt;
        digitCntNext = DigitCnt;
        failCntNext  = FailCnt;
        failInc      = (FailCnt < FAIL_MAX) ? FailCnt + 3'd1 : FailCnt;

        case (state)
            LOCKED: begin
                if (clearPulse) begin
                    digitCntNext = '0;
                end else if (enterPulse) begin
                    // Digit 0 occupies the top nibble, so slot index is 3 - DigitCnt.
                    slotsNext[~DigitCnt] = DigitIn;
                    digitCntNext         = DigitCnt + 2'd1;
                    if (DigitCnt == 2'd3) begin
                        stateNext = CHECK;
                    end
                end
            end
            CHECK: begin
                if (slots == CODE) begin
                    stateNext   = UNLOCKED;
                    failCntNext = '0;
                end else begin
                    failCntNext = failInc;
                    if (failInc == FAIL_MAX) begin
                        stateNext   = LOCKOUT;
                        lockCntNext = LOCK_LOAD;
                    end else begin
                        stateNext = LOCKED;
                    end
                end
            end
            UNLOCKED: begin
                if (clearPulse) begin
                    stateNext    = LOCKED;
                    digitCntNext = '0;
                end
            end
            LOCKOUT: begin
                if (lockCnt == '0) begin
                    stateNext   = LOCKED;
                    failCntNext = '0;
                end else begin
                    lockCntNext = lockCnt - LOCK_W'(1);
                end
            end
            default: stateNext = LOCKED;
        endcase

        dispNext     = dispCode(stateNext);
        unlockedNext = (stateNext == UNLOCKED);
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed and randomized checks of combo_lock_ctrl against a transaction-level lock model.
module tb_combo_lock_ctrl;

    localparam logic [15:0] CODE      = 16'h1234;
    localparam int          MAX_FAILS = 3;
    localparam int          LOCK_CYC  = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] DigitIn = 4'h0;
    logic       BtnEnter = 1'b0;
    logic       BtnClear = 1'b0;
    logic [3:0] DispVal;
    logic       Unlocked;
    logic [1:0] DigitCnt;
    logic [2:0] FailCnt;

    combo_lock_ctrl #(
        .CODE(CODE), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .Clk(Clk), .Rst(Rst), .DigitIn(DigitIn), .BtnEnter(BtnEnter), .BtnClear(BtnClear),
        .DispVal(DispVal), .Unlocked(Unlocked), .DigitCnt(DigitCnt), .FailCnt(FailCnt)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: digits entered so far, consecutive fails, open/closed.
    logic [3:0] mDigits[$];
    int         mFails    = 0;
    bit         mUnlocked = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "_digitcnt"}, 32'(DigitCnt), 32'(mDigits.size()));
        chk({tag, "_failcnt"},  32'(FailCnt),  32'(mFails));
        chk({tag, "_disp"},     32'(DispVal),  mUnlocked ? 32'd1 : 32'd0);
        chk({tag, "_unlocked"}, 32'(Unlocked), 32'(mUnlocked));
    endtask

    task automatic mReset();
        mDigits.delete();
        mFails    = 0;
        mUnlocked = 1'b0;
    endtask

    function automatic logic [3:0] codeDigit(input int i);
        logic [15:0] c;
        c = CODE;
        return c[15 - 4*i -: 4];
    endfunction

    // Apply one button event to the model; reports whether it starts a lockout.
    task automatic modelPress(input bit e, input bit c, input logic [3:0] d, output bit lockout);
        logic [15:0] v;
        lockout = 1'b0;
        if (c) begin
            mUnlocked = 1'b0;
            mDigits.delete();
        end else if (e && !mUnlocked) begin
            mDigits.push_back(d);
            if (mDigits.size() == 4) begin
                v = {mDigits[0], mDigits[1], mDigits[2], mDigits[3]};
                mDigits.delete();
                if (v == CODE) begin
                    mUnlocked = 1'b1;
                    mFails    = 0;
                end else begin
                    if (mFails < MAX_FAILS) mFails++;
                    if (mFails == MAX_FAILS) lockout = 1'b1;
                end
            end
        end
    endtask

    task automatic press(input bit e, input bit c, input logic [3:0] d);
        @(negedge Clk);
        DigitIn  = d;
        BtnEnter = e;
        BtnClear = c;
        repeat (3) @(negedge Clk);
        BtnEnter = 1'b0;
        BtnClear = 1'b0;
    endtask

    task automatic waitHold(output int waited);
        waited = 0;
        while (DispVal !== 4'h2 && waited < 12) begin
            @(negedge Clk);
            waited++;
        end
        chk("lockout_enter", 32'(DispVal), 32'd2);
    endtask

    // Measure the hold period while hammering both buttons in its early part.
    task automatic checkLockout();
        int w;
        int len;
        waitHold(w);
        len = 0;
        while (DispVal === 4'h2 && len < 100) begin
            chk("lockout_digitcnt", 32'(DigitCnt), 32'd0);
            len++;
            if (len <= 10) begin
                BtnEnter = 1'($urandom_range(0, 1));
                BtnClear = 1'($urandom_range(0, 1));
                DigitIn  = 4'($urandom_range(0, 15));
            end else begin
                BtnEnter = 1'b0;
                BtnClear = 1'b0;
            end
            @(negedge Clk);
        end
        BtnEnter = 1'b0;
        BtnClear = 1'b0;
        chk("lockout_len", 32'(len), 32'(LOCK_CYC));
        mFails = 0;
        repeat (4) @(negedge Clk);
        checkAll("after_lockout");
    endtask

    task automatic step(input string tag, input bit e, input bit c, input logic [3:0] d);
        bit lo;
        press(e, c, d);
        modelPress(e, c, d, lo);
        if (lo) begin
            checkLockout();
        end else begin
            repeat (3) @(negedge Clk);
            checkAll(tag);
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1 mReset();
        checkAll(tag);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        bit lo;
        int w;

        doReset("reset");

        // Correct code opens the lock two cycles after the last accepted press.
        step("d1", 1, 0, 4'h1);
        step("d2", 1, 0, 4'h2);
        step("d3", 1, 0, 4'h3);
        press(1, 0, 4'h4);
        modelPress(1, 0, 4'h4, lo);
        @(negedge Clk);
        chk("check_cycle_disp", 32'(DispVal), 32'd0);
        chk("check_cycle_digitcnt", 32'(DigitCnt), 32'd0);
        @(negedge Clk);
        checkAll("open_latency");

        step("unlocked_enter", 1, 0, 4'h5);
        step("unlocked_clear", 0, 1, 4'h0);

        // Three wrong entries lead to a timed hold.
        for (int a = 0; a < 3; a++) begin
            step("wrong1", 1, 0, 4'h1);
            step("wrong2", 1, 0, 4'h2);
            step("wrong3", 1, 0, 4'h3);
            step("wrong4", 1, 0, 4'h5);
        end

        // Simultaneous Enter and Clear: clear wins.
        step("sim1", 1, 0, 4'h1);
        step("sim2", 1, 0, 4'h2);
        step("sim_both", 1, 1, 4'h7);
        step("sim_a", 1, 0, 4'h1);
        step("sim_b", 1, 0, 4'h2);
        step("sim_c", 1, 0, 4'h3);
        step("sim_d", 1, 0, 4'h4);
        step("sim_relock", 0, 1, 4'h0);

        // Reset mid-entry.
        step("mid1", 1, 0, 4'h1);
        step("mid2", 1, 0, 4'h2);
        doReset("reset_mid_entry");
        step("re_a", 1, 0, 4'h1);
        step("re_b", 1, 0, 4'h2);
        step("re_c", 1, 0, 4'h3);
        step("re_d", 1, 0, 4'h4);
        step("re_relock", 0, 1, 4'h0);

        // Reset in the fifth hold cycle.
        for (int a = 0; a < 2; a++) begin
            step("pre_w1", 1, 0, 4'h9);
            step("pre_w2", 1, 0, 4'h9);
            step("pre_w3", 1, 0, 4'h9);
            step("pre_w4", 1, 0, 4'h9);
        end
        step("lo_w1", 1, 0, 4'h9);
        step("lo_w2", 1, 0, 4'h9);
        step("lo_w3", 1, 0, 4'h9);
        press(1, 0, 4'h9);
        modelPress(1, 0, 4'h9, lo);
        chk("lo_expected", 32'(lo), 32'd1);
        waitHold(w);
        repeat (4) @(negedge Clk);
        chk("lo_fifth_disp", 32'(DispVal), 32'd2);
        #2 Rst = 1'b1;
        #1 mReset();
        checkAll("reset_mid_lockout");
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        step("rl_a", 1, 0, 4'h1);
        step("rl_b", 1, 0, 4'h2);
        step("rl_c", 1, 0, 4'h3);
        step("rl_d", 1, 0, 4'h4);
        step("rl_relock", 0, 1, 4'h0);

        // Enter held through reset release must not count as a press.
        @(negedge Clk);
        Rst      = 1'b1;
        DigitIn  = 4'h9;
        BtnEnter = 1'b1;
        mReset();
        @(negedge Clk);
        Rst = 1'b0;
        repeat (8) @(negedge Clk);
        checkAll("held_through_reset");
        BtnEnter = 1'b0;
        repeat (4) @(negedge Clk);
        step("after_held", 1, 0, 4'h1);
        step("after_held_clr", 0, 1, 4'h0);

        // Randomized sequence, biased toward the correct code.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [3:0] d;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0 && mDigits.size() < 4)
                d = codeDigit(mDigits.size());
            else
                d = 4'($urandom_range(0, 15));
            if (r <= 6)      step("rnd_enter", 1, 0, d);
            else if (r <= 8) step("rnd_clear", 0, 1, d);
            else             step("rnd_both", 1, 1, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE, default 16'h1234, meaning the 4-digit hex combination; digit 0 is [15:12] and is entered first.
REQ-002 SHALL have parameter MAX_FAILS, default 3, meaning the consecutive wrong entries that trigger lockout (range 1..7).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 100_000_000, meaning the Clk cycles spent in lockout (minimum 2).
REQ-004 Clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-005 Rst  input  1  meaning the reset, asynchronous and active-high.
REQ-006 DigitIn  input  4  meaning the switch value of the digit being entered; treated as quasi-static and sampled only on an accepted Enter.
REQ-007 BtnEnter  input  1  meaning the debounced, asynchronous Enter button level.
REQ-008 BtnClear  input  1  meaning the debounced, asynchronous Clear/relock button level.
REQ-009 DispVal  output  4  meaning the status code for the seven-segment decoder: 4'h0 locked (L), 4'h1 unlocked (U), 4'h2 lockout/hold (H).
REQ-010 Unlocked  output  1  meaning high only in state UNLOCKED.
REQ-011 DigitCnt  output  2  meaning the number of digits captured in the current attempt.
REQ-012 FailCnt  output  3  meaning the consecutive failed attempts.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector; one accepted press is a single-cycle pulse, nominally 3 Clk edges after the button rises.
REQ-014 The FSM SHALL have states LOCKED, CHECK, UNLOCKED and LOCKOUT.
REQ-015 In LOCKED, an Enter pulse SHALL store DigitIn into slot DigitCnt and increment DigitCnt. On the 4th capture, DigitCnt SHALL wrap to 0 and the next state SHALL be CHECK.
REQ-016 CHECK SHALL last exactly one cycle and compare the four slots with CODE.
REQ-017 On a match, CHECK SHALL go to UNLOCKED and clear FailCnt.
REQ-018 On a mismatch, CHECK SHALL increment FailCnt. If the new FailCnt equals MAX_FAILS, the next state SHALL be LOCKOUT; otherwise LOCKED.
REQ-019 LOCKOUT SHALL load a down-counter with LOCKOUT_CYCLES-1 on entry. It SHALL return to LOCKED with FailCnt=0 in the cycle after the counter reaches 0, giving exactly LOCKOUT_CYCLES cycles in LOCKOUT.
REQ-020 In LOCKED, a Clear pulse SHALL discard captured digits (DigitCnt=0) and SHALL leave FailCnt unchanged.
REQ-021 In UNLOCKED, a Clear pulse SHALL relock the next cycle with DigitCnt=0; Enter pulses in UNLOCKED SHALL be ignored.
REQ-022 Enter and Clear pulses in LOCKOUT and CHECK SHALL be ignored, so lockout cannot be bypassed.
REQ-023 If Enter and Clear pulse in the same cycle, Clear SHALL win and no digit SHALL be captured.
REQ-024 DispVal and Unlocked SHALL be registered and SHALL reflect the current state: LOCKED and CHECK give 4'h0, UNLOCKED gives 4'h1, LOCKOUT gives 4'h2.
REQ-025 Unused DispVal codes SHALL never be driven.
REQ-026 FailCnt SHALL saturate at MAX_FAILS and never wrap.

Reset
REQ-027 Rst high SHALL immediately force: state LOCKED, DispVal=4'h0, Unlocked=0, DigitCnt=0, FailCnt=0, digit slots=0, lockout counter=0, synchronizer and edge flops=0.
REQ-028 Reset asserted mid-entry or mid-lockout SHALL abandon the operation; the first press after release SHALL be captured as digit 0.
REQ-029 A button already held high through reset release SHALL NOT generate a pulse until it is released and pressed again.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration and the display-code constants DISP_LOCKED=4'h0, DISP_UNLOCKED=4'h1 and DISP_HOLD=4'h2; the seven-segment decoder consumes these same constants.
REQ-031 One sub-module, btn_edge_sync (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated once per button.

Verification (CODE=16'h1234, MAX_FAILS=3, LOCKOUT_CYCLES=16)
REQ-032 Reset, enter 1,2,3,4 -> DispVal 4'h1 and Unlocked=1 two cycles after the 4th pulse; FailCnt=0.
REQ-033 Enter 1,2,3,5 three times -> FailCnt 1 then 2; on the 3rd attempt DispVal=4'h2 for exactly 16 cycles, then 4'h0 with FailCnt=0.
REQ-034 During lockout, press Enter and Clear repeatedly -> no change to DigitCnt, duration or DispVal=4'h2.
REQ-035 Enter 1,2, then Enter and Clear in the same cycle, then 1,2,3,4 -> DigitCnt 0 after the Clear, final DispVal 4'h1.
REQ-036 Assert Rst after 2 digits and again in the 5th lockout cycle -> all outputs 0 immediately; the following 1,2,3,4 unlocks.
REQ-037 From UNLOCKED, press Enter -> ignored; press Clear -> DispVal 4'h0 and Unlocked=0.
